// File: rtl/ascon_ps_inv_seq.sv
// rtl/ascon_ps_inv_seq.sv - iterative inverse Ascon S-box layer over a 320-bit state
// Substitutes COLS bit-sliced columns per clock; valid/ready on both sides.
module ascon_ps_inv_seq #(
    parameter int COLS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_state
);
    localparam int N  = 64 / COLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic [319:0]  work_q, work_d;
    logic [319:0]  subst;
    logic [8:0]    base;

    logic [COLS-1:0] g0, g1, g2, g3, g4;
    logic [COLS-1:0] h0, h1, h2, h3, h4;
    logic [4:0]      nib;

    function automatic logic [4:0] inv_sbox(input logic [4:0] c);
        logic [4:0] r;
        case (c)
            5'h00: r = 5'h14;  5'h01: r = 5'h1a;  5'h02: r = 5'h07;  5'h03: r = 5'h0d;
            5'h04: r = 5'h00;  5'h05: r = 5'h09;  5'h06: r = 5'h0e;  5'h07: r = 5'h12;
            5'h08: r = 5'h0a;  5'h09: r = 5'h06;  5'h0a: r = 5'h1d;  5'h0b: r = 5'h01;
            5'h0c: r = 5'h19;  5'h0d: r = 5'h15;  5'h0e: r = 5'h13;  5'h0f: r = 5'h1e;
            5'h10: r = 5'h18;  5'h11: r = 5'h16;  5'h12: r = 5'h0b;  5'h13: r = 5'h11;
            5'h14: r = 5'h03;  5'h15: r = 5'h05;  5'h16: r = 5'h1c;  5'h17: r = 5'h1f;
            5'h18: r = 5'h17;  5'h19: r = 5'h1b;  5'h1a: r = 5'h04;  5'h1b: r = 5'h08;
            5'h1c: r = 5'h0f;  5'h1d: r = 5'h0c;  5'h1e: r = 5'h10;  default: r = 5'h02;
        endcase
        return r;
    endfunction

    // Pull the current column group out of each of the five lanes, substitute, write back.
    always_comb begin
        base = 9'(col_idx_q) * 9'(COLS);
        g0 = work_q[9'd256 + base +: COLS];
        g1 = work_q[9'd192 + base +: COLS];
        g2 = work_q[9'd128 + base +: COLS];
        g3 = work_q[9'd64  + base +: COLS];
        g4 = work_q[base +: COLS];
        h0 = '0;
        h1 = '0;
        h2 = '0;
        h3 = '0;
        h4 = '0;
        nib = '0;
        for (int k = 0; k < COLS; k++) begin
            nib   = inv_sbox({g0[k], g1[k], g2[k], g3[k], g4[k]});
            h0[k] = nib[4];
            h1[k] = nib[3];
            h2[k] = nib[2];
            h3[k] = nib[1];
            h4[k] = nib[0];
        end
        subst = work_q;
        subst[9'd256 + base +: COLS] = h0;
        subst[9'd192 + base +: COLS] = h1;
        subst[9'd128 + base +: COLS] = h2;
        subst[9'd64  + base +: COLS] = h3;
        subst[base +: COLS]          = h4;
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d    = in_state;
                    col_idx_d = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                work_d = subst;
                if (col_idx_q == LAST) begin
                    col_idx_d = '0;
                    state_d   = S_DONE;
                end else begin
                    col_idx_d = col_idx_q + CW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_idx_q <= '0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
        end
    end

    assign out_state = work_q;

endmodule

// File: tb/tb_ascon_ps_inv_seq.sv
// tb/tb_ascon_ps_inv_seq.sv - self-checking bench for ascon_ps_inv_seq at COLS 1, 8, 64
module tb_ascon_ps_inv_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [319:0] in_state = '0;
    int           sel = 1;

    logic         iv [3];
    logic         ir [3];
    logic         ov [3];
    logic [319:0] os [3];
    logic         cur_ir, cur_ov;
    logic [319:0] cur_os;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [4:0] fwd_tab [32];
    logic [4:0] inv_tab [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        iv[0] = in_valid && (sel == 0);
        iv[1] = in_valid && (sel == 1);
        iv[2] = in_valid && (sel == 2);
        cur_ir = ir[sel];
        cur_ov = ov[sel];
        cur_os = os[sel];
    end

    ascon_ps_inv_seq #(.COLS(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
        .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]));
    ascon_ps_inv_seq #(.COLS(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
        .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]));
    ascon_ps_inv_seq #(.COLS(64)) u_c64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
        .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]));

    function automatic int n_of(input int s);
        return (s == 0) ? 64 : (s == 1) ? 8 : 1;
    endfunction

    function automatic logic [319:0] sub_layer(input logic [319:0] s, input logic inverse);
        logic [319:0] r;
        logic [4:0]   c, v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            c = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
            v = inverse ? inv_tab[c] : fwd_tab[c];
            r[256+j] = v[4];
            r[192+j] = v[3];
            r[128+j] = v[2];
            r[64+j]  = v[1];
            r[j]     = v[0];
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: a block that is either free or holding one state accepted at edge m_acc.
    logic         m_busy = 1'b0;
    int           m_acc = 0;
    logic [319:0] m_exp = '0;
    always @(negedge clk) begin
        logic exp_ov;
        if (rst) begin
            m_busy = 1'b0;
        end else begin
            exp_ov = m_busy && (cyc >= m_acc + n_of(sel));
            chk("mon_in_ready", cur_ir, !m_busy);
            chk("mon_out_valid", cur_ov, exp_ov);
            if (exp_ov) chk("mon_out_state", cur_os, m_exp);
            if (!m_busy && in_valid) begin
                m_busy = 1'b1;
                m_acc  = cyc + 1;
                m_exp  = sub_layer(in_state, 1'b1);
            end else if (exp_ov && out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic do_xfer(input logic [319:0] s, output logic [319:0] r, output int lat);
        int t;
        t = 0;
        in_state = s;
        in_valid = 1'b1;
        while (!cur_ir && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = cur_os;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [319:0] r, s, held;
        int lat, t;
        int acc [4];
        int cnt;

        fwd_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        for (int i = 0; i < 32; i++) inv_tab[fwd_tab[i]] = 5'(i);
        chk("inv_tab_00", 320'(inv_tab[5'h00]), 320'h14);
        chk("inv_tab_1f", 320'(inv_tab[5'h1f]), 320'h02);
        chk("inv_tab_04", 320'(inv_tab[5'h04]), 320'h00);
        chk("inv_tab_0b", 320'(inv_tab[5'h0b]), 320'h01);

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            chk("reset_in_ready", cur_ir, 1'b1);
            chk("reset_out_valid", cur_ov, 1'b0);
            chk("reset_out_state", cur_os, '0);
        end
        sel = 1;
        @(posedge clk); #1;
        rst = 1'b0;

        do_xfer('0, r, lat);
        chk("zero_latency", lat, 8);
        chk("zero_result", r, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});

        do_xfer({320{1'b1}}, r, lat);
        chk("ones_latency", lat, 8);
        chk("ones_result", r, {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        for (int k = 0; k < 3; k++) begin
            sel = k;
            cnt = (k == 2) ? 334 : 333;
            for (int i = 0; i < cnt; i++) begin
                s = rand_state();
                do_xfer(sub_layer(s, 1'b0), r, lat);
                chk("roundtrip_state", r, s);
                chk("roundtrip_latency", lat, n_of(k));
            end
        end

        sel = 1;
        out_ready = 1'b0;
        s = rand_state();
        do_xfer(s, r, lat);
        held = r;
        chk("bp_result", held, sub_layer(s, 1'b1));
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                in_state = rand_state();
                in_valid = 1'b1;
            end
            if (c == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            chk("bp_hold_state", cur_os, held);
            chk("bp_in_ready", cur_ir, 1'b0);
            chk("bp_out_valid", cur_ov, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", cur_ir, 1'b1);
        chk("bp_release_out_valid", cur_ov, 1'b0);

        in_state = rand_state();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", cur_ov, 1'b0);
        chk("rst_out_state", cur_os, '0);
        chk("rst_in_ready", cur_ir, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        s = rand_state();
        do_xfer(s, r, lat);
        chk("post_rst_result", r, sub_layer(s, 1'b1));
        chk("post_rst_latency", lat, 8);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_state = rand_state();
            in_valid = 1'b1;
            t = 0;
            while (!cur_ir && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk); #1;
            acc[i] = cyc;
        end
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 10);
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_final_idle", cur_ir, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
